// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the byte-enabled simple-dual-port RAM
package ram_pkg;
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;
    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/ram_sdp_be_if.sv
// ram_sdp_be_if: write/read/clear bus of the simple-dual-port RAM
interface ram_sdp_be_if import ram_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) ();
    logic                      clr;
    logic                      we;
    logic [be_w(DATA_W)-1:0]   be;
    logic [ADDR_W-1:0]         waddr;
    logic [DATA_W-1:0]         data;
    logic                      re;
    logic [ADDR_W-1:0]         raddr;
    logic [DATA_W-1:0]         q;
    logic                      rvalid;
    logic                      busy;
    modport master (output clr, we, be, waddr, data, re, raddr, input q, rvalid, busy);
    modport slave  (input clr, we, be, waddr, data, re, raddr, output q, rvalid, busy);
endinterface

// File: rtl/ram_clr_seq.sv
// ram_clr_seq: CLEAR/IDLE sequencer that sweeps zeros through every address
module ram_clr_seq import ram_pkg::*; #(
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    // restart the sweep on reset or request; leave CLEAR after the last address
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) r_state <= ST_IDLE;
        end
    end
    assign o_busy     = r_state == ST_CLEAR;
    assign o_clr_we   = r_state == ST_CLEAR;
    assign o_clr_addr = r_cnt;
endmodule

// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple-dual-port RAM with byte enables, read valid, RDW policy and clear sweep
module ram_sdp_be import ram_pkg::*; #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int RDW_MODE = RDW_OLD
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    ram_sdp_be_if.slave      bus
);
    localparam int BE_W  = be_w(DATA_W);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;
    logic              r_rvalid;
    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_uwe;
    logic              w_ure;
    logic              w_wr;
    logic [BE_W-1:0]   w_be;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    ram_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (bus.clr),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );
    // user accesses only count when idle and not pre-empted by a clear request
    assign w_uwe   = bus.we & ~w_busy & ~bus.clr;
    assign w_ure   = bus.re & ~w_busy & ~bus.clr;
    assign w_wr    = w_busy ? w_clr_we : w_uwe;
    assign w_be    = w_busy ? {BE_W{1'b1}} : bus.be;
    assign w_waddr = w_busy ? w_clr_addr : bus.waddr;
    assign w_wdata = w_busy ? '0 : bus.data;
    // byte-wise array write; the sweep writes full zero words
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < BE_W; i++)
            if (w_wr && w_be[i]) r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
    end
    // read word, with enabled write bytes forwarded in write-through mode
    always_comb begin
        w_rdata = r_mem[bus.raddr];
        for (int i = 0; i < BE_W; i++)
            if (RDW_MODE == RDW_NEW && w_uwe && bus.waddr == bus.raddr && bus.be[i])
                w_rdata[8*i +: 8] = bus.data[8*i +: 8];
    end
    // registered read port; Q holds when no read is accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q      <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_ure;
            if (w_ure) r_q <= w_rdata;
        end
    end
    assign bus.q      = r_q;
    assign bus.rvalid = r_rvalid;
    assign bus.busy   = w_busy;
endmodule

// File: tb/tb_ram_sdp_be.sv
// tb_ram_sdp_be: randomized and directed checks of an 8-bit read-first and a 32-bit write-through RAM
module tb_ram_sdp_be;
    import ram_pkg::*;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;
    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clr, we, re;
    logic [3:0]    be;
    logic [AW-1:0] waddr, raddr;
    logic [31:0]   data;
    int            n_chk = 0;
    int            n_err = 0;
    logic [7:0]    m8  [DEPTH];
    logic [31:0]   m32 [DEPTH];
    logic [7:0]    q8;
    logic [31:0]   q32;
    logic          rv;
    int            clr_left;

    ram_sdp_be_if #(.DATA_W(8),  .ADDR_W(AW)) if8 ();
    ram_sdp_be_if #(.DATA_W(32), .ADDR_W(AW)) if32 ();
    assign if8.clr   = clr;
    assign if8.we    = we;
    assign if8.be    = be[0];
    assign if8.waddr = waddr;
    assign if8.data  = data[7:0];
    assign if8.re    = re;
    assign if8.raddr = raddr;
    assign if32.clr   = clr;
    assign if32.we    = we;
    assign if32.be    = be;
    assign if32.waddr = waddr;
    assign if32.data  = data;
    assign if32.re    = re;
    assign if32.raddr = raddr;

    ram_sdp_be #(.DATA_W(8),  .ADDR_W(AW), .RDW_MODE(RDW_OLD)) u8  (.i_clk(clk), .i_rst_n(rst_n), .bus(if8.slave));
    ram_sdp_be #(.DATA_W(32), .ADDR_W(AW), .RDW_MODE(RDW_NEW)) u32 (.i_clk(clk), .i_rst_n(rst_n), .bus(if32.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] en);
        for (int i = 0; i < 4; i++)
            if (en[i]) old[8*i +: 8] = nw[8*i +: 8];
        return old;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, " busy8"},  32'(if8.busy),    32'(clr_left > 0));
        check({tag, " busy32"}, 32'(if32.busy),   32'(clr_left > 0));
        check({tag, " rv8"},    32'(if8.rvalid),  32'(rv));
        check({tag, " rv32"},   32'(if32.rvalid), 32'(rv));
        check({tag, " q8"},     32'(if8.q),       32'(q8));
        check({tag, " q32"},    if32.q,           q32);
    endtask

    // apply current inputs to the reference model, clock one edge, then compare
    task automatic step(input string tag);
        if (clr) begin
            clr_left = DEPTH;
            rv = 1'b0;
        end else if (clr_left > 0) begin
            clr_left--;
            rv = 1'b0;
            if (clr_left == 0)
                for (int a = 0; a < DEPTH; a++) begin
                    m8[a]  = '0;
                    m32[a] = '0;
                end
        end else begin
            rv = re;
            if (re) begin
                q8  = m8[raddr];
                q32 = (we && waddr == raddr) ? merge(m32[raddr], data, be) : m32[raddr];
            end
            if (we) begin
                if (be[0]) m8[waddr] = data[7:0];
                m32[waddr] = merge(m32[waddr], data, be);
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input string tag, input logic c, input logic w, input logic r, input logic [3:0] b,
                         input logic [AW-1:0] wa, input logic [AW-1:0] ra, input logic [31:0] d);
        clr = c; we = w; re = r; be = b; waddr = wa; raddr = ra; data = d;
        step(tag);
    endtask

    task automatic rand_cycle(input string tag, input int clr_pct);
        drive(tag, 1'($urandom_range(99) < clr_pct), 1'($urandom), 1'($urandom), 4'($urandom),
              AW'($urandom_range(7)), AW'($urandom_range(7)), $urandom);
    endtask

    // asynchronous reset asserted mid-cycle, checked before any edge
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        q8 = '0; q32 = '0; rv = 1'b0; clr_left = DEPTH;
        check_outputs(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clr = 0; we = 0; re = 0; be = 0; waddr = 0; raddr = 0; data = 0;
        do_reset("reset");
        for (int i = 0; i < DEPTH; i++) drive("sweep", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive("read_zero", 0, 0, 1, 0, 0, AW'(i), 0);
        drive("wr5", 0, 1, 0, 4'hF, 5, 0, 32'h5A5A5AA5);
        drive("rd5", 0, 0, 1, 0, 0, 5, 0);
        check("rd5 q8 value", 32'(if8.q), 32'hA5);
        drive("hold5", 0, 0, 0, 0, 0, 5, 0);
        check("hold5 q8 value", 32'(if8.q), 32'hA5);
        drive("wr3", 0, 1, 0, 4'hF, 3, 0, 32'h11223344);
        drive("wr3be", 0, 1, 0, 4'b0101, 3, 0, 32'hAABBCCDD);
        drive("rd3", 0, 0, 1, 0, 0, 3, 0);
        check("rd3 q32 value", if32.q, 32'h11BB33DD);
        drive("wr7", 0, 1, 0, 4'hF, 7, 0, 32'h10);
        drive("rdw7", 0, 1, 1, 4'hF, 7, 7, 32'h20);
        check("rdw7 old q8", 32'(if8.q), 32'h10);
        check("rdw7 new q32", if32.q, 32'h20);
        drive("rd7", 0, 0, 1, 0, 0, 7, 0);
        for (int i = 0; i < 300; i++) rand_cycle("random", 0);
        drive("clr_idle", 1, 1, 1, 4'hF, 5, 5, 32'hFFFFFFFF);
        for (int i = 0; i < 30; i++) rand_cycle("busy_acc", 0);
        drive("clr_mid", 1, 1, 1, 4'hF, 5, 5, 32'hFFFFFFFF);
        for (int i = 0; i < DEPTH; i++) rand_cycle("busy_acc2", 0);
        drive("rd5_clr", 0, 0, 1, 0, 0, 5, 0);
        for (int i = 0; i < 200; i++) rand_cycle("random_clr", 2);
        for (int i = 0; i < DEPTH; i++) drive("drain", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive("stream", 0, 0, 1, 0, 0, AW'(i), 0);
        do_reset("async_reset");
        for (int i = 0; i < DEPTH; i++) drive("resweep", 0, 0, 1, 4'hF, 1, 1, 32'hFF);
        for (int i = 0; i < 8; i++) rand_cycle("post_reset", 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, both on a single clock.
- Adds per-byte write enables, an explicit read enable with a registered valid output, a selectable read-during-write policy, and a hardware clear sequencer that zeroes every word after reset or on request.
- General storage block for register files, scratchpads and FIFO backing stores in the sequential library.

Parameters:
- DATA_W, 8, data word width in bits; must be a multiple of 8.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0, read-during-write to the same address: 0 = old data (read-first), 1 = new data (write-through, merged per byte).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- CLR  input  1  single-cycle request to zero the whole array.
- WE  input  1  write request.
- BE  input  DATA_W/8  byte enables; bit i covers DATA[8i+7:8i].
- WADDR  input  ADDR_W  write address.
- DATA  input  DATA_W  write data.
- RE  input  1  read request.
- RADDR  input  ADDR_W  read address.
- Q  output  DATA_W  registered read data.
- RVALID  output  1  Q holds the data for the read issued on the previous cycle.
- BUSY  output  1  clear sweep in progress; WE and RE are ignored.

Behaviour:

Reset (RST_N low, asynchronous):
- Q=0, RVALID=0, BUSY=1.
- FSM goes to CLEAR with the sweep counter at 0.
- Array contents are undefined until the sweep completes.

FSM states:
- CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. After the cycle that writes address DEPTH-1, the FSM goes to IDLE. BUSY is 1 throughout.
- IDLE: BUSY=0. Normal write and read operation.

Clear timing:
- The sweep lasts exactly DEPTH cycles.
- BUSY falls on the DEPTH-th rising edge after RST_N rises.

Clear requests:
- CLR in IDLE: go to CLEAR with cnt=0 on the next edge. BUSY=1 from that edge.
- CLR in CLEAR: restart the sweep with cnt=0. Completion is delayed accordingly.
- CLR has priority over WE/RE in the same cycle; that write is dropped and that read gets no RVALID.

Write (IDLE, WE=1):
- For each i with BE[i]=1, mem[WADDR] byte i takes DATA byte i on the edge.
- Bytes with BE[i]=0 are unchanged.
- WE=1 with BE=0 is a no-op.

Read (IDLE, RE=1):
- On edge n, Q takes mem[RADDR] and RVALID=1; both are visible after edge n. Latency is 1 cycle.
- With RE=0 (or BUSY=1): RVALID=0 next cycle and Q holds its last value.
- Back-to-back reads give one result per cycle.

Read-during-write (RE and WE in the same cycle, RADDR==WADDR):
- RDW_MODE=0: Q gets the pre-write word.
- RDW_MODE=1: Q gets the pre-write word with the enabled bytes replaced by DATA.
- If the addresses differ, there is no interaction.

BUSY cycles:
- WE and RE are ignored entirely: no write, no RVALID.
- Q is not zeroed by the sweep; it holds its last value.

Reset mid-operation:
- Asynchronous reset aborts any sweep or access and restarts CLEAR from 0.

Address wrap:
- The counter is ADDR_W+1 bits or compares against DEPTH-1; no out-of-range address exists.

Decomposition:
- Shared package ram_pkg:
  - state enum {ST_CLEAR, ST_IDLE};
  - RDW_OLD=0 and RDW_NEW=1 constants;
  - a function returning the byte-enable width DATA_W/8.
- One natural sub-module, ram_clr_seq: the CLEAR/IDLE FSM plus the sweep counter.
  - Outputs: BUSY, clear-write strobe, clear address.
  - The top level muxes clear writes versus user writes into the storage array.

Test Plan:
- Release RST_N, hold WE=RE=0 -> BUSY=1 for exactly 64 cycles (default params), then 0. Reading all 64 addresses afterwards returns 0x00 with RVALID=1 each cycle after RE.
- After clear, WE=1 BE=1 WADDR=5 DATA=0xA5; next cycle RE=1 RADDR=5 -> one cycle later Q=0xA5, RVALID=1. With RE=0 the following cycle -> RVALID=0 and Q stays 0xA5.
- DATA_W=32: write 0x11223344 to addr 3, then WE BE=4'b0101 DATA=0xAABBCCDD -> read addr 3 gives 0x11BB33DD.
- Same-cycle WE/RE to addr 7 (old value 0x10, new 0x20, BE all ones) -> RDW_MODE=0 gives Q=0x10; RDW_MODE=1 gives Q=0x20. Reading addr 7 next gives 0x20 in both modes.
- Mid-sweep CLR at cycle 30 -> BUSY stays high for 64 cycles from the restart edge. WE/RE issued during BUSY cause no write and RVALID=0. Addr 5 reads 0x00 afterwards.
- Assert RST_N low asynchronously mid-cycle during a back-to-back read stream -> Q=0, RVALID=0, BUSY=1 immediately, without waiting for an edge. A full sweep follows release.
